// File: rtl/ctrl_fsm_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ctrl_fsm_pkg                                               |
// | Description : Shared definitions for the multi-cycle RV32I control FSM:  |
// |               opcode constants, immediate-format and writeback-source    |
// |               encodings, state and instruction-class enums, and small    |
// |               class-to-datapath-select helpers.                          |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package ctrl_fsm_pkg;

   // RV32I major opcodes (inst[6:0]); every one ends in 2'b11
   localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
   localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
   localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
   localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
   localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] c_OPC_OP     = 7'b0110011;
   localparam logic [6:0] c_OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] c_OPC_SYSTEM = 7'b1110011;

   // Immediate format select
   localparam logic [2:0] c_IMM_U    = 3'b000;
   localparam logic [2:0] c_IMM_J    = 3'b001;
   localparam logic [2:0] c_IMM_I    = 3'b010;
   localparam logic [2:0] c_IMM_B    = 3'b011;
   localparam logic [2:0] c_IMM_S    = 3'b100;
   localparam logic [2:0] c_IMM_NONE = 3'b111;

   // Writeback source select
   localparam logic [1:0] c_WB_ALU = 2'b00;
   localparam logic [1:0] c_WB_MEM = 2'b01;
   localparam logic [1:0] c_WB_PC4 = 2'b10;
   localparam logic [1:0] c_WB_IMM = 2'b11;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_ERR    = 3'd7
   } state_e;

   typedef enum logic [3:0] {
      CL_LUI     = 4'd0,
      CL_AUIPC   = 4'd1,
      CL_JAL     = 4'd2,
      CL_JALR    = 4'd3,
      CL_BRANCH  = 4'd4,
      CL_LOAD    = 4'd5,
      CL_STORE   = 4'd6,
      CL_OPIMM   = 4'd7,
      CL_OP      = 4'd8,
      CL_FENCE   = 4'd9,
      CL_SYSTEM  = 4'd10,
      CL_ILLEGAL = 4'd11
   } iclass_e;

   // ALU operand A takes the PC for PC-relative classes
   function automatic logic alu_a_is_pc(input iclass_e cls);
      return (cls == CL_AUIPC) || (cls == CL_JAL) || (cls == CL_BRANCH);
   endfunction

   // ALU operand B takes the immediate for everything but register-register
   function automatic logic alu_b_is_imm(input iclass_e cls);
      return (cls == CL_OPIMM) || (cls == CL_LOAD) || (cls == CL_STORE) ||
             (cls == CL_JALR)  || (cls == CL_AUIPC) || (cls == CL_JAL) ||
             (cls == CL_BRANCH);
   endfunction

   function automatic logic [1:0] wb_sel_of(input iclass_e cls);
      logic [1:0] sel;
      sel = c_WB_ALU;
      if (cls == CL_LOAD)                          sel = c_WB_MEM;
      else if ((cls == CL_JAL) || (cls == CL_JALR)) sel = c_WB_PC4;
      else if (cls == CL_LUI)                      sel = c_WB_IMM;
      return sel;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_fsm_decode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ctrl_decode                                                |
// | Description : Combinational opcode classifier.                           |
// |   opcode_i  [6:0] in  : inst[6:0]                                        |
// |   class_o         out : instruction class                                |
// |   immsel_o  [2:0] out : immediate format for the class                   |
// |   illegal_o       out : opcode outside RV32I (incl. inst[1:0] != 2'b11)  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module ctrl_decode
   import ctrl_fsm_pkg::*;
(
   input  logic [6:0] opcode_i,
   output iclass_e    class_o,
   output logic [2:0] immsel_o,
   output logic       illegal_o
);

   // Full 7-bit match: because every legal opcode ends in 2'b11, a
   // compressed-style low field falls through to the illegal default.
   always_comb begin
      class_o  = CL_ILLEGAL;
      immsel_o = c_IMM_NONE;
      case (opcode_i)
         c_OPC_LUI:    begin class_o = CL_LUI;    immsel_o = c_IMM_U;    end
         c_OPC_AUIPC:  begin class_o = CL_AUIPC;  immsel_o = c_IMM_U;    end
         c_OPC_JAL:    begin class_o = CL_JAL;    immsel_o = c_IMM_J;    end
         c_OPC_JALR:   begin class_o = CL_JALR;   immsel_o = c_IMM_I;    end
         c_OPC_LOAD:   begin class_o = CL_LOAD;   immsel_o = c_IMM_I;    end
         c_OPC_OPIMM:  begin class_o = CL_OPIMM;  immsel_o = c_IMM_I;    end
         c_OPC_BRANCH: begin class_o = CL_BRANCH; immsel_o = c_IMM_B;    end
         c_OPC_STORE:  begin class_o = CL_STORE;  immsel_o = c_IMM_S;    end
         c_OPC_OP:     begin class_o = CL_OP;     immsel_o = c_IMM_NONE; end
         c_OPC_FENCE:  begin class_o = CL_FENCE;  immsel_o = c_IMM_NONE; end
         c_OPC_SYSTEM: begin class_o = CL_SYSTEM; immsel_o = c_IMM_NONE; end
         default:      begin class_o = CL_ILLEGAL; immsel_o = c_IMM_NONE; end
      endcase
      illegal_o = (class_o == CL_ILLEGAL);
   end

endmodule
`default_nettype wire

// File: rtl/ctrl_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ctrl_fsm                                                   |
// | Description : Multi-cycle RV32I control unit                             |
// |               (FETCH/DECODE/EXEC/MEM/WB/ERR) with memory-wait timeout.   |
// |   clk, rst (sync, active-high)                                           |
// |   inst[31:0], mem_rdata_vld, br_taken                      : inputs      |
// |   immsel_g[2:0], ir_we, pc_we, reg_we, mem_re, mem_we, mem_is_inst,      |
// |   alu_a_sel, alu_b_sel, wb_sel[1:0], pc_sel, err, state_o[2:0]: outputs  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module ctrl_fsm
   import ctrl_fsm_pkg::*;
#(
   parameter int MEM_WAIT_MAX = 255   // 0 disables the wait timeout
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] inst,
   input  logic        mem_rdata_vld,
   input  logic        br_taken,
   output logic [2:0]  immsel_g,
   output logic        ir_we,
   output logic        pc_we,
   output logic        reg_we,
   output logic        mem_re,
   output logic        mem_we,
   output logic        mem_is_inst,
   output logic        alu_a_sel,
   output logic        alu_b_sel,
   output logic [1:0]  wb_sel,
   output logic        pc_sel,
   output logic        err,
   output logic [2:0]  state_o
);

   // Counter only needs to reach MEM_WAIT_MAX-1 before the timeout fires
   localparam int c_CNT_W = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
   localparam logic [c_CNT_W-1:0] c_WAIT_LAST =
      c_CNT_W'((MEM_WAIT_MAX > 0) ? MEM_WAIT_MAX - 1 : 0);

   state_e               state_q, state_d;
   iclass_e              class_q;
   logic [2:0]           immsel_q;
   logic                 rd_nz_q;
   logic [c_CNT_W-1:0]   wcnt_q;

   iclass_e              w_dec_class;
   logic [2:0]           w_dec_immsel;
   logic                 w_dec_illegal;
   logic                 w_timeout;
   logic                 w_unused_inst;

   assign w_unused_inst = ^inst[31:12];

   ctrl_decode u_decode (
      .opcode_i  (inst[6:0]),
      .class_o   (w_dec_class),
      .immsel_o  (w_dec_immsel),
      .illegal_o (w_dec_illegal)
   );

   // Fires on the wait cycle that would bring the count to MEM_WAIT_MAX
   assign w_timeout = (MEM_WAIT_MAX != 0) && !mem_rdata_vld && (wcnt_q == c_WAIT_LAST);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_FETCH: begin
            if (mem_rdata_vld)  state_d = ST_DECODE;
            else if (w_timeout) state_d = ST_ERR;
         end
         ST_DECODE: state_d = w_dec_illegal ? ST_ERR : ST_EXEC;
         ST_EXEC: begin
            case (class_q)
               CL_BRANCH, CL_FENCE, CL_SYSTEM: state_d = ST_FETCH;
               CL_LOAD, CL_STORE:              state_d = ST_MEM;
               default:                        state_d = ST_WB;
            endcase
         end
         ST_MEM: begin
            if (mem_rdata_vld)  state_d = (class_q == CL_LOAD) ? ST_WB : ST_FETCH;
            else if (w_timeout) state_d = ST_ERR;
         end
         ST_WB:   state_d = ST_FETCH;
         ST_ERR:  state_d = ST_ERR;
         default: state_d = ST_ERR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_FETCH;
         class_q  <= CL_ILLEGAL;
         immsel_q <= c_IMM_NONE;
         rd_nz_q  <= 1'b0;
         wcnt_q   <= '0;
      end else begin
         state_q <= state_d;
         // Capture everything later states need so inst is not consulted again
         if (state_q == ST_DECODE) begin
            class_q  <= w_dec_class;
            immsel_q <= w_dec_immsel;
            rd_nz_q  <= |inst[11:7];
         end else if (state_d == ST_FETCH) begin
            immsel_q <= c_IMM_NONE;
         end
         if (state_d != state_q)
            wcnt_q <= '0;
         else if (((state_q == ST_FETCH) || (state_q == ST_MEM)) && !mem_rdata_vld)
            wcnt_q <= wcnt_q + c_CNT_W'(1);
      end
   end

   // Outputs depend on registered state/class; the only input terms are the
   // memory handshake and the branch result, sampled where they are consumed.
   // rst forces all strobes and requests low in the reset cycle itself.
   always_comb begin
      ir_we       = 1'b0;
      pc_we       = 1'b0;
      reg_we      = 1'b0;
      mem_re      = 1'b0;
      mem_we      = 1'b0;
      mem_is_inst = 1'b0;
      alu_a_sel   = 1'b0;
      alu_b_sel   = 1'b0;
      wb_sel      = c_WB_ALU;
      pc_sel      = 1'b0;
      if (!rst) begin
         case (state_q)
            ST_FETCH: begin
               mem_re      = 1'b1;
               mem_is_inst = 1'b1;
               ir_we       = mem_rdata_vld;
            end
            ST_EXEC: begin
               alu_a_sel = alu_a_is_pc(class_q);
               alu_b_sel = alu_b_is_imm(class_q);
               if (class_q == CL_BRANCH) begin
                  pc_we  = 1'b1;
                  pc_sel = br_taken;
               end else if ((class_q == CL_FENCE) || (class_q == CL_SYSTEM)) begin
                  pc_we = 1'b1;
               end
            end
            ST_MEM: begin
               alu_a_sel = alu_a_is_pc(class_q);
               alu_b_sel = alu_b_is_imm(class_q);
               mem_re    = (class_q == CL_LOAD);
               mem_we    = (class_q == CL_STORE);
               pc_we     = (class_q == CL_STORE) && mem_rdata_vld;
            end
            ST_WB: begin
               alu_a_sel = alu_a_is_pc(class_q);
               alu_b_sel = alu_b_is_imm(class_q);
               reg_we    = rd_nz_q;
               pc_we     = 1'b1;
               wb_sel    = wb_sel_of(class_q);
               pc_sel    = (class_q == CL_JAL) || (class_q == CL_JALR);
            end
            default: ;
         endcase
      end
   end

   assign immsel_g = (state_q == ST_DECODE) ? w_dec_immsel : immsel_q;
   assign err      = (state_q == ST_ERR);
   assign state_o  = state_q;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_ctrl_fsm                                                |
// | Description : Self-checking bench for ctrl_fsm. Each instruction is      |
// |               expanded into an expected per-cycle trace from the         |
// |               instruction's class and the chosen memory wait counts,     |
// |               then driven and compared cycle by cycle.                   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_ctrl_fsm;

   localparam int WMAX = 4;

   // instruction kinds as the bench sees them
   localparam int K_LUI = 0, K_AUIPC = 1, K_JAL = 2, K_JALR = 3, K_BR = 4, K_LD = 5,
                  K_ST = 6, K_OPI = 7, K_OP = 8, K_FENCE = 9, K_SYS = 10, K_ILL = 11;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] inst = '0;
   logic        mem_rdata_vld = 1'b0;
   logic        br_taken = 1'b0;
   logic [2:0]  immsel_g;
   logic        ir_we, pc_we, reg_we, mem_re, mem_we, mem_is_inst;
   logic        alu_a_sel, alu_b_sel, pc_sel, err;
   logic [1:0]  wb_sel;
   logic [2:0]  state_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ctrl_fsm #(.MEM_WAIT_MAX(WMAX)) dut (
      .clk(clk), .rst(rst), .inst(inst), .mem_rdata_vld(mem_rdata_vld),
      .br_taken(br_taken), .immsel_g(immsel_g), .ir_we(ir_we), .pc_we(pc_we),
      .reg_we(reg_we), .mem_re(mem_re), .mem_we(mem_we), .mem_is_inst(mem_is_inst),
      .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .wb_sel(wb_sel),
      .pc_sel(pc_sel), .err(err), .state_o(state_o)
   );

   typedef struct {
      string       tag;
      logic        rst, vld, br;
      logic [31:0] inst;
      logic [2:0]  st;
      logic        irw, pcw, rgw, mre, mwe, mii, er;
      logic        cimm;
      logic [2:0]  imm;
      logic        a, b;
      logic [1:0]  wb;
      logic        pcs;
   } cyc_t;

   cyc_t q[$];

   function automatic int kind_of(input logic [31:0] i);
      case (i[6:0])
         7'h37: return K_LUI;   7'h17: return K_AUIPC; 7'h6F: return K_JAL;
         7'h67: return K_JALR;  7'h63: return K_BR;    7'h03: return K_LD;
         7'h23: return K_ST;    7'h13: return K_OPI;   7'h33: return K_OP;
         7'h0F: return K_FENCE; 7'h73: return K_SYS;
         default: return K_ILL;
      endcase
   endfunction

   function automatic logic [2:0] imm_of(input int k);
      case (k)
         K_LUI, K_AUIPC:       return 3'b000;
         K_JAL:                return 3'b001;
         K_JALR, K_LD, K_OPI:  return 3'b010;
         K_BR:                 return 3'b011;
         K_ST:                 return 3'b100;
         default:              return 3'b111;
      endcase
   endfunction

   function automatic logic [6:0] opc_pick(input int n);
      case (n)
         0: return 7'h37; 1: return 7'h17; 2: return 7'h6F; 3: return 7'h67;
         4: return 7'h63; 5: return 7'h03; 6: return 7'h23; 7: return 7'h13;
         8: return 7'h33; 9: return 7'h0F; default: return 7'h73;
      endcase
   endfunction

   // Idle cycle template: no strobes, don't-care inputs randomised
   function automatic cyc_t mk(input string tag, input logic [2:0] st, input logic [31:0] ins);
      cyc_t c;
      c.tag = tag; c.rst = 1'b0;
      c.vld = 1'($urandom_range(0, 1)); c.br = 1'($urandom_range(0, 1));
      c.inst = ins; c.st = st;
      c.irw = 0; c.pcw = 0; c.rgw = 0; c.mre = 0; c.mwe = 0; c.mii = 0; c.er = 0;
      c.cimm = 1'b1; c.imm = 3'b111; c.a = 0; c.b = 0; c.wb = 2'b00; c.pcs = 0;
      return c;
   endfunction

   // Two cycles parked in ERR, then a reset cycle that brings it back to FETCH
   task automatic push_err(input string tag);
      cyc_t c;
      for (int n = 0; n < 3; n++) begin
         c = mk(tag, 3'd7, $urandom());
         c.er = 1'b1; c.cimm = 1'b0; c.rst = (n == 2);
         q.push_back(c);
      end
   endtask

   // Expand one instruction into its expected trace.
   // fw/mw: cycles mem_rdata_vld stays low in FETCH/MEM (>= WMAX times out).
   // rst_mem: assert rst on the second MEM cycle, abandoning the instruction.
   task automatic build(input logic [31:0] ins, input int fw, input int mw,
                        input logic br, input bit rst_mem, input string tag);
      int         k  = kind_of(ins);
      logic [2:0] im = imm_of(k);
      cyc_t       c;
      for (int n = 0; n <= fw && n < WMAX; n++) begin
         c = mk(tag, 3'd0, $urandom());   // IR not yet loaded: inst is stale
         c.mre = 1; c.mii = 1; c.vld = (n == fw); c.irw = (n == fw);
         q.push_back(c);
      end
      if (fw >= WMAX) begin push_err(tag); return; end
      c = mk(tag, 3'd1, ins);
      c.imm = im; c.cimm = (k != K_ILL);
      q.push_back(c);
      if (k == K_ILL) begin push_err(tag); return; end
      c = mk(tag, 3'd2, ins);
      c.imm = im; c.br = br;
      c.a = (k == K_AUIPC || k == K_JAL || k == K_BR);
      c.b = !(k == K_OP || k == K_LUI || k == K_FENCE || k == K_SYS);
      if (k == K_BR) begin c.pcw = 1; c.pcs = br; end
      if (k == K_FENCE || k == K_SYS) c.pcw = 1;
      q.push_back(c);
      if (k == K_BR || k == K_FENCE || k == K_SYS) return;
      if (k == K_LD || k == K_ST) begin
         for (int n = 0; n <= mw && n < WMAX; n++) begin
            c = mk(tag, 3'd3, ins);
            c.imm = im; c.mre = (k == K_LD); c.mwe = (k == K_ST); c.vld = (n == mw);
            if (rst_mem && n == 1) begin
               c.rst = 1; c.vld = 0; c.mre = 0; c.mwe = 0;
               q.push_back(c);
               return;
            end
            if (k == K_ST && n == mw) c.pcw = 1;
            q.push_back(c);
         end
         if (mw >= WMAX) begin push_err(tag); return; end
         if (k == K_ST) return;
      end
      c = mk(tag, 3'd4, ins);
      c.imm = im; c.rgw = (ins[11:7] != 5'd0); c.pcw = 1;
      c.wb  = (k == K_LD) ? 2'b01 : (k == K_JAL || k == K_JALR) ? 2'b10 :
              (k == K_LUI) ? 2'b11 : 2'b00;
      c.pcs = (k == K_JAL || k == K_JALR);
      q.push_back(c);
   endtask

   task automatic do_cycle(input cyc_t c);
      logic [6:0] o, e;
      rst = c.rst; mem_rdata_vld = c.vld; br_taken = c.br; inst = c.inst;
      @(negedge clk);
      o = {ir_we, pc_we, reg_we, mem_re, mem_we, mem_is_inst, err};
      e = {c.irw, c.pcw, c.rgw, c.mre, c.mwe, c.mii, c.er};
      checks++;
      assert (state_o === c.st) else begin
         errors++;
         $error("FAIL %s state: got %0d want %0d", c.tag, state_o, c.st);
      end
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s st%0d strobes{ir,pc,reg,re,we,inst,err}: got %b want %b",
                c.tag, c.st, o, e);
      end
      if (c.cimm) begin
         checks++;
         assert (immsel_g === c.imm) else begin
            errors++;
            $error("FAIL %s st%0d immsel_g: got %b want %b", c.tag, c.st, immsel_g, c.imm);
         end
      end
      if (c.st == 3'd2 && !c.rst) begin
         checks++;
         assert ({alu_a_sel, alu_b_sel} === {c.a, c.b}) else begin
            errors++;
            $error("FAIL %s alu_sel{a,b}: got %b%b want %b%b", c.tag,
                   alu_a_sel, alu_b_sel, c.a, c.b);
         end
      end
      if (c.st == 3'd4) begin
         checks++;
         assert (wb_sel === c.wb) else begin
            errors++;
            $error("FAIL %s wb_sel: got %b want %b", c.tag, wb_sel, c.wb);
         end
      end
      if (c.pcw) begin
         checks++;
         assert (pc_sel === c.pcs) else begin
            errors++;
            $error("FAIL %s pc_sel: got %b want %b", c.tag, pc_sel, c.pcs);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_q();
      while (q.size() > 0) do_cycle(q.pop_front());
   endtask

   initial begin
      cyc_t        c;
      logic [31:0] r;
      logic [6:0]  opc;
      int          fw, mw;

      // First edge applies reset; the following reset cycle checks the reset state
      @(posedge clk);
      #1;
      c = mk("reset", 3'd0, 32'h0);
      c.rst = 1'b1;
      q.push_back(c);
      run_q();

      build(32'h00500093, 0, 0, 1'b0, 1'b0, "addi");
      build(32'h00208463, 0, 0, 1'b1, 1'b0, "beq_taken");
      build(32'h00208463, 1, 0, 1'b0, 1'b0, "beq_not_taken");
      build(32'h0000A103, 0, 3, 1'b0, 1'b0, "lw_wait3");
      build(32'h00112023, 2, 1, 1'b0, 1'b0, "sw");
      build(32'h0000007F, 0, 0, 1'b0, 1'b0, "illegal");
      build(32'h00500013, 0, 0, 1'b0, 1'b0, "addi_rd0");
      build(32'h00000093, WMAX, 0, 1'b0, 1'b0, "fetch_timeout");
      build(32'h00112023, 0, WMAX, 1'b0, 1'b0, "mem_timeout");
      build(32'h00112023, 0, 3, 1'b0, 1'b1, "sw_reset_in_mem");
      build(32'h004000EF, 0, 0, 1'b0, 1'b0, "jal");
      build(32'h00008067, 0, 0, 1'b0, 1'b0, "jalr");
      build(32'h123450B7, 0, 0, 1'b0, 1'b0, "lui");
      build(32'h00000073, 0, 0, 1'b0, 1'b0, "ecall");
      build(32'h00000092, 0, 0, 1'b0, 1'b0, "low_bits_not_11");
      run_q();

      for (int i = 0; i < 80; i++) begin
         r = $urandom();
         if ($urandom_range(0, 11) == 0) begin
            opc = r[6:0];
            while (kind_of({25'd0, opc}) != K_ILL) opc = 7'($urandom());
         end else begin
            opc = opc_pick($urandom_range(0, 10));
         end
         r = {r[31:7], opc};
         if ($urandom_range(0, 3) == 0) r[11:7] = 5'd0;
         fw = ($urandom_range(0, 15) == 0) ? WMAX : $urandom_range(0, 3);
         mw = ($urandom_range(0, 15) == 0) ? WMAX + 1 : $urandom_range(0, 3);
         build(r, fw, mw, 1'($urandom_range(0, 1)), 1'b0, "rand");
         run_q();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ctrl_fsm.md
CTRL_FSM -- requirements
Module: ctrl_fsm

Interface
REQ-001 Parameter MEM_WAIT_MAX, default 255: maximum mem_ready wait cycles before timeout error; 0 disables the timeout.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 inst  input  32  instruction register contents; decoded in DECODE and later states.
REQ-005 mem_rdata_vld  input  1  memory ready/valid for the current mem_re or mem_we request.
REQ-006 br_taken  input  1  branch comparator result; sampled in EXEC only.
REQ-007 immsel_g  output  3  immediate format select: 000 U, 001 J, 010 I, 011 B, 100 S, 111 none.
REQ-008 ir_we, pc_we, reg_we  output  1 each  instruction register, PC and register-file write strobes.
REQ-009 mem_re, mem_we, mem_is_inst  output  1 each  memory read request, write request, and fetch-versus-data select.
REQ-010 alu_a_sel  output  1  0 = rs1, 1 = PC.
REQ-011 alu_b_sel  output  1  0 = rs2, 1 = immediate.
REQ-012 wb_sel  output  2  writeback source: 00 ALU, 01 memory, 10 PC+4, 11 immediate.
REQ-013 pc_sel  output  1  0 = PC+4, 1 = ALU result.
REQ-014 err  output  1  sticky error flag.
REQ-015 state_o  output  3  current state, for debug.

Function
REQ-016 States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ERR=7. The state register is one-hot internally or binary; state_o always carries the binary encoding.
REQ-017 FETCH: mem_re=1, mem_is_inst=1; hold until mem_rdata_vld=1; in that cycle ir_we=1, go to DECODE.
REQ-018 DECODE: classify inst[6:0]; drive immsel_g per class. LUI/AUIPC use 000, JAL 001, JALR/LOAD/OP-IMM 010, BRANCH 011, STORE 100, OP/FENCE/SYSTEM 111.
REQ-019 DECODE: an opcode outside the RV32I set, or inst[1:0]!=2'b11, goes to ERR; otherwise go to EXEC.
REQ-020 immsel_g is a registered copy of the DECODE value, held stable from DECODE through the last state of the instruction; it is 111 in FETCH.
REQ-021 EXEC: ALU selects per class:
 - OP: a=rs1, b=rs2.
 - OP-IMM/LOAD/STORE/JALR: a=rs1, b=imm.
 - AUIPC/JAL/BRANCH: a=PC, b=imm.
REQ-022 EXEC exits: BRANCH drives pc_we=1, pc_sel=br_taken, then FETCH; LOAD/STORE go to MEM; FENCE/ECALL/EBREAK drive pc_we=1, pc_sel=0, then FETCH; all others go to WB.
REQ-023 MEM: mem_re (LOAD) or mem_we (STORE) is held with mem_is_inst=0 until mem_rdata_vld=1.
REQ-024 MEM on mem_rdata_vld=1: LOAD goes to WB; STORE drives pc_we=1, pc_sel=0, then FETCH.
REQ-025 WB: reg_we=1 and pc_we=1 for exactly one cycle, then FETCH.
REQ-026 WB selects:
 - wb_sel: LOAD 01, JAL/JALR 10, LUI 11, others 00.
 - pc_sel: JAL/JALR 1, others 0.
REQ-027 reg_we is forced to 0 when inst[11:7]==0.
REQ-028 Latency from FETCH entry, with zero-wait memory: OP/OP-IMM/LUI/AUIPC/JAL/JALR 4 cycles; BRANCH/FENCE/SYSTEM 3; STORE 4; LOAD 5. Each memory wait cycle adds one cycle.
REQ-029 Every strobe (ir_we, pc_we, reg_we) is asserted for at most one cycle per instruction.
REQ-030 Memory timeout: a cycle counter runs in FETCH and MEM. It goes to ERR when it reaches MEM_WAIT_MAX without mem_rdata_vld, and clears on each state change.
REQ-031 ERR: all strobes and requests are 0, err=1; the block stays in ERR until rst.
REQ-032 All outputs are decoded from the state and registered instruction class only, with no combinational path from inst to strobes outside DECODE.

Reset
REQ-033 rst=1 at a clock edge: the next state is FETCH, err=0, immsel_g=111, wait counter=0.
REQ-034 During and after reset, until FETCH is re-entered, all strobes and requests are 0. Reset mid-instruction abandons the instruction with no further write strobes.

Structure
REQ-035 The shared package holds the opcode constants, the immsel encodings (U/J/I/B/S/none), the wb_sel encodings, the state enum, and the instruction-class enum.
REQ-036 One sub-module, ctrl_decode, performs the combinational classification of opcode to class, immsel and illegal flag. The FSM and counter live in ctrl_fsm.

Verification
REQ-037 addi x1,x0,5 (0x00500093), zero-wait memory: state sequence 0,1,2,4,0; immsel_g=010 from DECODE; reg_we=1 only in WB; wb_sel=00.
REQ-038 beq (0x00208463): with br_taken=1, pc_we=1 and pc_sel=1 in EXEC (cycle 3); with br_taken=0, pc_sel=0; reg_we never asserted; immsel_g=011.
REQ-039 lw (0x0000A103) with mem_rdata_vld low 3 cycles in MEM: MEM lasts 4 cycles; total 8 cycles; wb_sel=01 in WB.
REQ-040 Illegal opcode 0x0000007F: ERR entered after DECODE; err=1; no strobes thereafter; rst returns to FETCH with err=0.
REQ-041 MEM_WAIT_MAX=4, mem_rdata_vld held low in FETCH: ERR entered 4 cycles after FETCH entry.
REQ-042 rst asserted in MEM during a sw (0x00112023): mem_we=0 from the next cycle; state_o=0; no pc_we for the aborted store.
